// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// wb_pkg : shared types and load-formatting helpers for the writeback stage
// Rev 1.0
// ============================================================================
package wb_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] value;
  } wb_entry_t;

  typedef enum logic [0:0] {
    ARB_NORMAL = 1'b0,
    ARB_FORCE  = 1'b1
  } wb_arb_state_e;

  function automatic logic ld_legal(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_LB, F3_LBU: ld_legal = 1'b1;
      F3_LH, F3_LHU: ld_legal = ~lo[0];
      F3_LW:         ld_legal = (lo == 2'b00);
      default:       ld_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ld_format(input logic [2:0] f3, input logic [1:0] lo,
                                            input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lo, 3'b000} +: 8];
    h = lo[1] ? w[31:16] : w[15:0];
    case (f3)
      F3_LB:   ld_format = {{24{b[7]}}, b};
      F3_LBU:  ld_format = {24'b0, b};
      F3_LH:   ld_format = {{16{h[15]}}, h};
      F3_LHU:  ld_format = {16'b0, h};
      default: ld_format = w;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_if.sv
`default_nettype none
// ============================================================================
// wb_if : ALU / load-response / register-file-write bundle of the writeback stage
// Optional forwarding signals under WB_FORWARD_EN. Rev 1.0
// ============================================================================
interface wb_if;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_result;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic [31:0] ld_rdata;
  logic        rf_write_enable;
  logic [4:0]  rf_write_address;
  logic [31:0] rf_write_value;
  logic        ld_err;
`ifdef WB_FORWARD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_value;
  logic [4:0]  fwd_q_rd;
  logic        fwd_q_hit;
  logic [31:0] fwd_q_value;
`endif

  modport master (
    output alu_valid, alu_rd, alu_result,
    output ld_valid, ld_rd, ld_funct3, ld_addr_lo, ld_rdata,
    input  alu_ready, ld_ready,
    input  rf_write_enable, rf_write_address, rf_write_value, ld_err
`ifdef WB_FORWARD_EN
    , input fwd_valid, fwd_rd, fwd_value, fwd_q_hit, fwd_q_value
    , output fwd_q_rd
`endif
  );

  modport slave (
    input  alu_valid, alu_rd, alu_result,
    input  ld_valid, ld_rd, ld_funct3, ld_addr_lo, ld_rdata,
    output alu_ready, ld_ready,
    output rf_write_enable, rf_write_address, rf_write_value, ld_err
`ifdef WB_FORWARD_EN
    , output fwd_valid, fwd_rd, fwd_value, fwd_q_hit, fwd_q_value
    , input fwd_q_rd
`endif
  );
endinterface
`default_nettype wire

// File: rtl/wb_load_queue.sv
`default_nettype none
// ============================================================================
// wb_load_queue : circular FIFO of formatted load results (youngest-first search
// under WB_FORWARD_EN). Rev 1.0
// ============================================================================
module wb_load_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push_i,
  input  wb_entry_t push_entry_i,
  input  logic      pop_i,
  output wb_entry_t head_o,
  output logic      full_o,
  output logic      empty_o
`ifdef WB_FORWARD_EN
  , input  logic [4:0]  q_rd_i
  , output logic        q_hit_o
  , output logic [31:0] q_value_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             w_push, w_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage needs no reset: the count alone defines which slots are live.
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= push_entry_i;
  end

`ifdef WB_FORWARD_EN
  always_comb begin
    q_hit_o   = 1'b0;
    q_value_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count_q) && (mem_q[rd_ptr_q + PTR_W'(i)].rd == q_rd_i)) begin
        q_hit_o   = 1'b1;
        q_value_o = mem_q[rd_ptr_q + PTR_W'(i)].value;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// writeback_stage : arbitrates ALU results and queued loads onto one registered
// register-file write port. Optional forwarding via WB_FORWARD_EN. Rev 1.0
// ============================================================================
module writeback_stage
  import wb_pkg::*;
#(
  parameter int LQ_DEPTH     = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic clk,
  input logic rst_n,
  wb_if.slave bus
);

  localparam int SC_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;

  wb_arb_state_e   state_q, state_d;
  logic [SC_W-1:0] starve_q, starve_d;
  logic            we_q, we_d;
  logic [4:0]      wa_q, wa_d;
  logic [31:0]     wv_q, wv_d;
  logic            err_q, err_d;

  logic      w_full, w_empty, w_push, w_pop;
  logic      w_alu_acc, w_ld_acc, w_ld_ok, w_ld_live;
  wb_entry_t w_head, w_push_entry;

  assign bus.alu_ready = (state_q == ARB_NORMAL);
  assign bus.ld_ready  = ~w_full;
  assign w_alu_acc     = bus.alu_valid & bus.alu_ready;
  assign w_ld_acc      = bus.ld_valid & bus.ld_ready;
  assign w_ld_ok       = ld_legal(bus.ld_funct3, bus.ld_addr_lo);
  assign w_ld_live     = w_ld_acc & (bus.ld_rd != 5'd0);
  assign w_push        = w_ld_live & w_ld_ok;
  assign w_push_entry  = '{rd: bus.ld_rd, value: ld_format(bus.ld_funct3, bus.ld_addr_lo, bus.ld_rdata)};
  // The head only drains when the ALU cannot be accepted, so writes never collide.
  assign w_pop         = ~w_empty & ((state_q == ARB_FORCE) | ~bus.alu_valid);

  wb_load_queue #(.DEPTH(LQ_DEPTH)) u_lq (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (w_push),
    .push_entry_i (w_push_entry),
    .pop_i        (w_pop),
    .head_o       (w_head),
    .full_o       (w_full),
    .empty_o      (w_empty)
`ifdef WB_FORWARD_EN
    , .q_rd_i     (bus.fwd_q_rd)
    , .q_hit_o    (bus.fwd_q_hit)
    , .q_value_o  (bus.fwd_q_value)
`endif
  );

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    if (w_empty || w_pop) begin
      starve_d = '0;
    end else if ((state_q == ARB_NORMAL) && bus.alu_valid) begin
      starve_d = starve_q + SC_W'(1);
    end
    case (state_q)
      ARB_NORMAL: begin
        if (!w_empty && !w_pop && bus.alu_valid &&
            ((int'(starve_q) + 1) >= (STARVE_LIMIT - 1)))
          state_d = ARB_FORCE;
      end
      ARB_FORCE: begin
        if (w_pop) state_d = ARB_NORMAL;
      end
      default: state_d = ARB_NORMAL;
    endcase
  end

  always_comb begin
    we_d  = 1'b0;
    wa_d  = wa_q;
    wv_d  = wv_q;
    err_d = w_ld_live & ~w_ld_ok;
    if (w_pop) begin
      we_d = 1'b1;
      wa_d = w_head.rd;
      wv_d = w_head.value;
    end else if (w_alu_acc && (bus.alu_rd != 5'd0)) begin
      we_d = 1'b1;
      wa_d = bus.alu_rd;
      wv_d = bus.alu_result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB_NORMAL;
      starve_q <= '0;
      we_q     <= 1'b0;
      wa_q     <= '0;
      wv_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      we_q     <= we_d;
      wa_q     <= wa_d;
      wv_q     <= wv_d;
      err_q    <= err_d;
    end
  end

  assign bus.rf_write_enable  = we_q;
  assign bus.rf_write_address = wa_q;
  assign bus.rf_write_value   = wv_q;
  assign bus.ld_err           = err_q;

`ifdef WB_FORWARD_EN
  assign bus.fwd_valid = we_q;
  assign bus.fwd_rd    = wa_q;
  assign bus.fwd_value = wv_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
// tb_writeback_stage : directed scenarios plus randomized traffic against a
// queue-based reference model. Rev 1.0
// ============================================================================
module tb_writeback_stage;

  localparam int LQ_DEPTH     = 2;
  localparam int STARVE_LIMIT = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  wb_if bus ();

  writeback_stage #(.LQ_DEPTH(LQ_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
  } exp_t;

  exp_t model_q[$];

`ifdef WB_FORWARD_EN
  initial bus.fwd_q_rd = 5'd0;
`endif

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_valid  = 1'b0;
    bus.alu_rd     = 5'd0;
    bus.alu_result = 32'd0;
    bus.ld_valid   = 1'b0;
    bus.ld_rd      = 5'd0;
    bus.ld_funct3  = 3'd0;
    bus.ld_addr_lo = 2'd0;
    bus.ld_rdata   = 32'd0;
  endtask

  // Reference load formatting from the ISA rules using plain shifts and arithmetic.
  function automatic bit ref_load(input int unsigned f3, input int unsigned lo,
                                  input logic [31:0] w, output logic [31:0] v);
    int unsigned x;
    v = 32'd0;
    case (f3)
      0, 4: begin
        x = (w >> (8 * lo)) & 32'hFF;
        v = (f3 == 0 && x >= 128) ? 32'(x - 32'd256) : x;
        return 1'b1;
      end
      1, 5: begin
        if (lo % 2 != 0) return 1'b0;
        x = (w >> (16 * (lo / 2))) & 32'hFFFF;
        v = (f3 == 1 && x >= 32768) ? 32'(x - 32'd65536) : x;
        return 1'b1;
      end
      2: begin
        if (lo != 0) return 1'b0;
        v = w;
        return 1'b1;
      end
      default: return 1'b0;
    endcase
  endfunction

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.rf_write_enable !== 1'b0 || bus.rf_write_address !== 5'd0 ||
        bus.rf_write_value !== 32'd0 || bus.ld_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: we=%b addr=%0d val=%h err=%b, expected all zero",
               bus.rf_write_enable, bus.rf_write_address, bus.rf_write_value, bus.ld_err);
    end
    checks++;
    if (bus.ld_ready !== 1'b1 || bus.alu_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: ld_ready=%b alu_ready=%b, expected 1/1", bus.ld_ready, bus.alu_ready);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (bus.ld_ready !== 1'b1 || bus.alu_ready !== 1'b1 || bus.rf_write_enable !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: ld_ready=%b alu_ready=%b we=%b, expected 1/1/0",
               bus.ld_ready, bus.alu_ready, bus.rf_write_enable);
    end
  endtask

  task automatic test_alu_write();
    idle_inputs();
    step();
    bus.alu_valid  = 1'b1;
    bus.alu_rd     = 5'd5;
    bus.alu_result = 32'hDEADBEEF;
    step();
    idle_inputs();
    checks++;
    if (bus.rf_write_enable !== 1'b1 || bus.rf_write_address !== 5'd5 ||
        bus.rf_write_value !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL alu_write: we=%b addr=%0d val=%h, expected 1/5/deadbeef",
               bus.rf_write_enable, bus.rf_write_address, bus.rf_write_value);
    end
    step();
    checks++;
    if (bus.rf_write_enable !== 1'b0) begin
      errors++;
      $display("FAIL alu_write_once: we=%b, expected 0", bus.rf_write_enable);
    end
  endtask

  task automatic test_load_format();
    logic [2:0]  f3 [2] = '{3'b000, 3'b101};
    logic [1:0]  lo [2] = '{2'd3, 2'd2};
    logic [31:0] wd [2] = '{32'h80FF_0000, 32'h8001_1234};
    logic [31:0] ex [2] = '{32'hFFFF_FF80, 32'h0000_8001};
    for (int i = 0; i < 2; i++) begin
      idle_inputs();
      bus.ld_valid   = 1'b1;
      bus.ld_rd      = 5'(10 + i);
      bus.ld_funct3  = f3[i];
      bus.ld_addr_lo = lo[i];
      bus.ld_rdata   = wd[i];
      step();
      idle_inputs();
      checks++;
      if (bus.rf_write_enable !== 1'b0) begin
        errors++;
        $display("FAIL load_latency_%0d: we=%b one cycle after accept, expected 0", i, bus.rf_write_enable);
      end
      step();
      checks++;
      if (bus.rf_write_enable !== 1'b1 || bus.rf_write_address !== 5'(10 + i) ||
          bus.rf_write_value !== ex[i]) begin
        errors++;
        $display("FAIL load_format_%0d: we=%b addr=%0d val=%h, expected 1/%0d/%h", i,
                 bus.rf_write_enable, bus.rf_write_address, bus.rf_write_value, 10 + i, ex[i]);
      end
      step();
    end
  endtask

  task automatic test_load_err();
    idle_inputs();
    bus.ld_valid   = 1'b1;
    bus.ld_rd      = 5'd12;
    bus.ld_funct3  = 3'b010;
    bus.ld_addr_lo = 2'd1;
    bus.ld_rdata   = 32'h1234_5678;
    step();
    idle_inputs();
    checks++;
    if (bus.ld_err !== 1'b1 || bus.rf_write_enable !== 1'b0) begin
      errors++;
      $display("FAIL lw_misaligned: err=%b we=%b, expected 1/0", bus.ld_err, bus.rf_write_enable);
    end
    step();
    checks++;
    if (bus.ld_err !== 1'b0 || bus.rf_write_enable !== 1'b0) begin
      errors++;
      $display("FAIL lw_misaligned_after: err=%b we=%b, expected 0/0", bus.ld_err, bus.rf_write_enable);
    end
    bus.ld_valid   = 1'b1;
    bus.ld_rd      = 5'd0;
    bus.ld_funct3  = 3'b000;
    bus.ld_addr_lo = 2'd0;
    bus.ld_rdata   = 32'h0000_00AA;
    step();
    idle_inputs();
    checks++;
    if (bus.ld_err !== 1'b0 || bus.rf_write_enable !== 1'b0) begin
      errors++;
      $display("FAIL lb_rd0: err=%b we=%b, expected 0/0", bus.ld_err, bus.rf_write_enable);
    end
    step();
    checks++;
    if (bus.rf_write_enable !== 1'b0) begin
      errors++;
      $display("FAIL lb_rd0_after: we=%b, expected 0", bus.rf_write_enable);
    end
  endtask

  task automatic test_starve();
    logic [31:0] v;
    v = $urandom;
    idle_inputs();
    bus.alu_valid  = 1'b1;
    bus.alu_rd     = 5'd0;
    bus.alu_result = $urandom;
    bus.ld_valid   = 1'b1;
    bus.ld_rd      = 5'd7;
    bus.ld_funct3  = 3'b010;
    bus.ld_rdata   = v;
    step();
    bus.ld_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (bus.alu_ready !== 1'(k < 4) || bus.rf_write_enable !== 1'b0) begin
        errors++;
        $display("FAIL starve_cycle_%0d: alu_ready=%b we=%b, expected %0d/0",
                 k, bus.alu_ready, bus.rf_write_enable, (k < 4));
      end
      step();
    end
    checks++;
    if (bus.rf_write_enable !== 1'b1 || bus.rf_write_address !== 5'd7 ||
        bus.rf_write_value !== v || bus.alu_ready !== 1'b1) begin
      errors++;
      $display("FAIL starve_write: we=%b addr=%0d val=%h alu_ready=%b, expected 1/7/%h/1",
               bus.rf_write_enable, bus.rf_write_address, bus.rf_write_value, bus.alu_ready, v);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3];
    int          wr_rd [$];
    logic [31:0] wr_val [$];
    int          idx = 0;
    logic        ready_third = 1'b1;
    for (int i = 0; i < 3; i++) vals[i] = $urandom;
    idle_inputs();
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd0;
    for (int c = 0; c < 40; c++) begin
      if (idx < 3) begin
        bus.ld_valid   = 1'b1;
        bus.ld_rd      = 5'(idx + 1);
        bus.ld_funct3  = 3'b010;
        bus.ld_addr_lo = 2'd0;
        bus.ld_rdata   = vals[idx];
      end else begin
        bus.ld_valid = 1'b0;
      end
      #1;
      if (c == 2) ready_third = bus.ld_ready;
      if (bus.ld_valid && bus.ld_ready) idx++;
      step();
      if (bus.rf_write_enable) begin
        wr_rd.push_back(int'(bus.rf_write_address));
        wr_val.push_back(bus.rf_write_value);
      end
    end
    idle_inputs();
    checks++;
    if (ready_third !== 1'b0) begin
      errors++;
      $display("FAIL b2b_full: ld_ready=%b on third offer, expected 0", ready_third);
    end
    checks++;
    if (idx != 3 || wr_rd.size() != 3) begin
      errors++;
      $display("FAIL b2b_count: accepted=%0d written=%0d, expected 3/3", idx, wr_rd.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wr_rd[i] != i + 1 || wr_val[i] !== vals[i]) begin
          errors++;
          $display("FAIL b2b_order_%0d: rd=%0d val=%h, expected %0d/%h",
                   i, wr_rd[i], wr_val[i], i + 1, vals[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int writes = 0;
    idle_inputs();
    bus.alu_valid  = 1'b1;
    bus.alu_rd     = 5'd0;
    bus.ld_valid   = 1'b1;
    bus.ld_rd      = 5'd20;
    bus.ld_funct3  = 3'b010;
    bus.ld_rdata   = $urandom;
    step();
    bus.ld_rd      = 5'd21;
    bus.ld_rdata   = $urandom;
    bus.alu_rd     = 5'd9;
    bus.alu_result = $urandom;
    step();
    checks++;
    if (bus.rf_write_enable !== 1'b1 || bus.ld_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_setup: we=%b ld_ready=%b, expected 1/0", bus.rf_write_enable, bus.ld_ready);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.rf_write_enable !== 1'b0 || bus.rf_write_address !== 5'd0 ||
        bus.rf_write_value !== 32'd0 || bus.ld_err !== 1'b0 ||
        bus.ld_ready !== 1'b1 || bus.alu_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_outputs: we=%b addr=%0d val=%h err=%b ldr=%b alur=%b, expected 0/0/0/0/1/1",
               bus.rf_write_enable, bus.rf_write_address, bus.rf_write_value, bus.ld_err,
               bus.ld_ready, bus.alu_ready);
    end
    idle_inputs();
    step();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      if (bus.rf_write_enable) writes++;
    end
    checks++;
    if (writes != 0 || bus.ld_ready !== 1'b1 || bus.alu_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_after: writes=%0d ld_ready=%b alu_ready=%b, expected 0/1/1",
               writes, bus.ld_ready, bus.alu_ready);
    end
  endtask

  task automatic test_random();
    int   blocked = 0;
    logic [31:0] v;
    model_q.delete();
    for (int c = 0; c < 460; c++) begin
      bit   exp_alu, exp_err, must_pop, had_entries, load_written, alu_acc, ld_acc;
      exp_t alu_e;
      if (c < 400) begin
        bus.alu_valid  = ($urandom_range(0, 9) < 7);
        bus.alu_rd     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        bus.alu_result = $urandom;
        bus.ld_valid   = ($urandom_range(0, 2) == 0);
        bus.ld_rd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        bus.ld_funct3  = 3'($urandom_range(0, 7));
        bus.ld_addr_lo = 2'($urandom_range(0, 3));
        bus.ld_rdata   = $urandom;
      end else begin
        idle_inputs();
      end
      #1;
      checks++;
      if (bus.ld_ready !== 1'(model_q.size() < LQ_DEPTH)) begin
        errors++;
        $display("FAIL rnd_ld_ready c=%0d: ld_ready=%b, expected %0d (queued=%0d)",
                 c, bus.ld_ready, (model_q.size() < LQ_DEPTH), model_q.size());
      end
      checks++;
      if (bus.alu_ready !== 1'b1 && model_q.size() == 0) begin
        errors++;
        $display("FAIL rnd_alu_ready c=%0d: alu_ready=%b with empty queue, expected 1", c, bus.alu_ready);
      end
      alu_acc     = bus.alu_valid && bus.alu_ready;
      ld_acc      = bus.ld_valid && bus.ld_ready;
      had_entries = (model_q.size() > 0);
      must_pop    = had_entries && !bus.alu_valid;
      exp_alu     = alu_acc && (bus.alu_rd != 5'd0);
      alu_e.rd    = bus.alu_rd;
      alu_e.val   = bus.alu_result;
      exp_err     = 1'b0;
      if (ld_acc && bus.ld_rd != 5'd0) begin
        if (ref_load(bus.ld_funct3, bus.ld_addr_lo, bus.ld_rdata, v)) begin
          exp_t e;
          e.rd  = bus.ld_rd;
          e.val = v;
          model_q.push_back(e);
        end else begin
          exp_err = 1'b1;
        end
      end
      step();
      load_written = 1'b0;
      checks++;
      if (exp_alu) begin
        if (bus.rf_write_enable !== 1'b1 || bus.rf_write_address !== alu_e.rd ||
            bus.rf_write_value !== alu_e.val) begin
          errors++;
          $display("FAIL rnd_alu c=%0d: we=%b addr=%0d val=%h, expected 1/%0d/%h", c,
                   bus.rf_write_enable, bus.rf_write_address, bus.rf_write_value, alu_e.rd, alu_e.val);
        end
      end else if (bus.rf_write_enable === 1'b1) begin
        if (!had_entries || bus.rf_write_address !== model_q[0].rd ||
            bus.rf_write_value !== model_q[0].val) begin
          errors++;
          $display("FAIL rnd_load c=%0d: addr=%0d val=%h, expected head %0d/%h (had_entries=%0d)", c,
                   bus.rf_write_address, bus.rf_write_value, model_q[0].rd, model_q[0].val, had_entries);
        end
        void'(model_q.pop_front());
        load_written = 1'b1;
      end else if (must_pop || bus.rf_write_enable !== 1'b0) begin
        errors++;
        $display("FAIL rnd_drain c=%0d: we=%b, expected a load write 1", c, bus.rf_write_enable);
      end
      checks++;
      if (bus.ld_err !== exp_err) begin
        errors++;
        $display("FAIL rnd_ld_err c=%0d: err=%b, expected %0d", c, bus.ld_err, exp_err);
      end
      blocked = (had_entries && !load_written) ? blocked + 1 : 0;
      checks++;
      if (blocked > STARVE_LIMIT - 1) begin
        errors++;
        $display("FAIL rnd_starve c=%0d: blocked=%0d cycles, expected at most %0d", c, blocked, STARVE_LIMIT - 1);
      end
    end
    checks++;
    if (model_q.size() != 0) begin
      errors++;
      $display("FAIL rnd_final: %0d loads never written, expected 0", model_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_load_format();
    test_load_err();
    test_starve();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 Parameter LQ_DEPTH, default 2, load-queue entries (power of two, 2..8).
REQ-002 Parameter STARVE_LIMIT, default 4, consecutive blocked cycles before a load is forced ahead of the ALU.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 alu_valid  input  1  ALU result offered.
REQ-006 alu_ready  output  1  ALU result accepted this cycle when high with alu_valid.
REQ-007 alu_rd  input  5  ALU destination register.
REQ-008 alu_result  input  32  ALU result.
REQ-009 ld_valid  input  1  load response offered.
REQ-010 ld_ready  output  1  load response accepted when high with ld_valid.
REQ-011 ld_rd  input  5  load destination register.
REQ-012 ld_funct3  input  3  load type (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
REQ-013 ld_addr_lo  input  2  byte offset of load address.
REQ-014 ld_rdata  input  32  raw aligned memory word.
REQ-015 rf_write_enable  output  1  register file write strobe.
REQ-016 rf_write_address  output  5  register file write index.
REQ-017 rf_write_value  output  32  register file write data.
REQ-018 ld_err  output  1  one-cycle pulse: illegal funct3 or misaligned load dropped.
REQ-019 fwd_valid / fwd_rd / fwd_value  output  1/5/32  forwarding copy of the pending write (present only with WB_FORWARD_EN).

Function
REQ-020 Write-port outputs SHALL be registered; an accepted ALU result appears on rf_write_* exactly 1 cycle after acceptance, for one cycle.
REQ-021 Loads SHALL be formatted at acceptance: byte/halfword selected by ld_addr_lo, sign-extended for LB/LH, zero-extended for LBU/LHU, LW passed through; formatted entry pushed into the load queue.
REQ-022 Misaligned LH/LHU (ld_addr_lo[0]=1), misaligned LW (ld_addr_lo!=0), or funct3 outside REQ-012 SHALL be accepted, not enqueued, and pulse ld_err the next cycle.
REQ-023 Any accepted result with rd=0 SHALL be discarded: no enqueue, no write, no ld_err.
REQ-024 ld_ready SHALL equal "queue not full"; a push and pop in the same cycle on a full queue SHALL NOT be allowed (ld_ready low when full).
REQ-025 Arbiter states NORMAL and FORCE: in NORMAL alu_ready=1 and queue head drains only in cycles with alu_valid=0; in FORCE alu_ready=0 and head drains.
REQ-026 Starve counter SHALL increment each cycle queue non-empty and alu_valid=1 in NORMAL, clear on any pop or empty queue; reaching STARVE_LIMIT-1 moves to FORCE; FORCE returns to NORMAL after exactly one pop.
REQ-027 Queued load popped in cycle N SHALL write in cycle N+1; minimum accept-to-write latency for a load is 2 cycles; loads retire in acceptance order.
REQ-028 At most one rf write per cycle; simultaneous ALU accept and load pop SHALL never occur.
REQ-029 Queue pointers SHALL wrap modulo LQ_DEPTH with a separate full/empty count of width clog2(LQ_DEPTH)+1.

Reset
REQ-030 On rst_n low: rf_write_enable=0, rf_write_address=0, rf_write_value=0, ld_err=0, fwd_valid=0, queue emptied, starve counter 0, state NORMAL; ld_ready=1 and alu_ready=1 during and after reset.
REQ-031 Reset asserted mid-operation SHALL discard queued loads and any pending write without issuing it.

Configuration
REQ-032 Macro WB_FORWARD_EN defined: fwd_* ports exist, fwd_valid=rf_write_enable, fwd_rd/fwd_value mirror write port, plus valid queue entries searched youngest-first for combinational query port pair fwd_q_rd(in,5)/fwd_q_hit,fwd_q_value(out).
REQ-033 WB_FORWARD_EN undefined: no fwd ports, no search logic; all other behaviour identical.

Structure
REQ-034 Shared package wb_pkg SHALL hold load funct3 constants, the queue entry typedef (rd 5, value 32) and the arbiter state enum.
REQ-035 Load queue SHALL be sub-module wb_load_queue (push/pop/full/empty, depth parameter).

Verification
REQ-036 ALU rd=5 value 0xDEADBEEF at cycle 3 -> rf write x5=0xDEADBEEF at cycle 4 only.
REQ-037 LB addr_lo=3 rdata=0x80FF_0000 -> x rd=0xFFFFFF80; LHU addr_lo=2 rdata=0x8001_1234 -> 0x00008001.
REQ-038 LW addr_lo=1 -> ld_err pulse, no write; LB rd=0 -> no write, no ld_err.
REQ-039 Continuous alu_valid with one queued load, STARVE_LIMIT=4 -> alu_ready low in 4th blocked cycle, load written next cycle, alu_ready high after.
REQ-040 Three loads back-to-back, alu_valid=1, LQ_DEPTH=2 -> ld_ready low after 2 accepts; writes in acceptance order.
REQ-041 rst_n low with 2 queued loads -> outputs zero, no writes after release, ld_ready=1.
